// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: owns the fetch PC, tracks the D-stage PC, holds the
// D instruction across stalls and delays the hazard flags by one cycle.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] KILL_PC  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] inst_tmp_1d,
  output logic        flush_1d,
  output logic        stall_1d
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_f_q, pc_f_d;
  logic [XLEN-1:0]   pc_d_q, pc_d_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d_d;
  logic [XLEN-1:0]   inst_tmp_q, inst_tmp_d;
  logic              flush_1d_q, flush_1d_d;
  logic              stall_1d_q, stall_1d_d;

  // State and datapath registers; reset has priority over every input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_f_q     <= RESET_PC;
      pc_d_q     <= KILL_PC;
      pc_plus4_q <= XLEN'(KILL_PC + PC_STEP);
      inst_tmp_q <= '0;
      flush_1d_q <= 1'b0;
      stall_1d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      pc_d_q     <= pc_d_d;
      pc_plus4_q <= pc_plus4_d_d;
      inst_tmp_q <= inst_tmp_d;
      flush_1d_q <= flush_1d_d;
      stall_1d_q <= stall_1d_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_q;
    inst_tmp_d   = inst_tmp_q;
    flush_1d_d   = 1'b0;
    stall_1d_d   = 1'b0;

    unique case (state_q)
      BOOT: begin
        // imem is capturing RESET_PC on this edge, so D gets RESET_PC next.
        state_d      = RUN;
        pc_d_d       = RESET_PC;
        pc_plus4_d_d = XLEN'(RESET_PC + PC_STEP);
        pc_f_d       = XLEN'(RESET_PC + PC_STEP);
      end
      RUN: begin
        flush_1d_d = flush;
        stall_1d_d = stall;

        if (pc_src) begin
          pc_f_d = pc_target;
        end else if (!stall) begin
          pc_f_d = XLEN'(pc_f_q + PC_STEP);
        end

        // pc_d follows whatever address imem is returning data for.
        if (!stall || pc_src) begin
          pc_d_d       = pc_f_q;
          pc_plus4_d_d = XLEN'(pc_f_q + PC_STEP);
        end

        // Snapshot D's instruction before imem re-reads the held F address.
        if (stall && !stall_1d_q) begin
          inst_tmp_d = imem_rdata;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_addr   = pc_f_q;
  assign pc_f        = pc_f_q;
  assign pc_d        = pc_d_q;
  assign pc_plus4_d  = pc_plus4_q;
  assign inst_tmp_1d = inst_tmp_q;
  assign flush_1d    = flush_1d_q;
  assign stall_1d    = stall_1d_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand sequences for wrap and
// reset-during-stall, then random traffic against a reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KILL_PC  = 32'h1000_0000;
  localparam logic [31:0] XMASK    = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, pc_src;
  logic [31:0] pc_target, imem_rdata;
  logic [31:0] imem_addr, pc_f, pc_d, pc_plus4_d, inst_tmp_1d;
  logic        flush_1d, stall_1d;

  logic        ovr_en;
  logic [31:0] ovr_val;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_boot;
  logic [31:0] m_pc_f, m_pc_d, m_tmp;
  logic        m_f1, m_s1;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] tgt;
    logic [31:0] e_pc_f;
    logic [31:0] e_pc_d;
    logic [31:0] e_tmp;
    logic        e_f1;
    logic        e_s1;
  } vec_t;

  vec_t vecs[16];

  fetch_ctrl #(.RESET_PC(RESET_PC), .KILL_PC(KILL_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .pc_f       (pc_f),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .inst_tmp_1d(inst_tmp_1d),
    .flush_1d   (flush_1d),
    .stall_1d   (stall_1d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ XMASK;
  endfunction

  // synchronous instruction memory, one-cycle latency
  always @(posedge clk) begin
    imem_rdata <= ovr_en ? ovr_val : mem_word(imem_addr);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge: predict from the rules, advance, compare every output.
  task automatic tick();
    logic [31:0] n_pc_f, n_pc_d, n_tmp;
    logic        n_f1, n_s1, n_boot;
    n_tmp = m_tmp;
    if (!rst_n) begin
      n_boot = 1'b1; n_pc_f = RESET_PC; n_pc_d = KILL_PC;
      n_tmp  = '0;   n_f1 = 1'b0;       n_s1 = 1'b0;
    end else if (m_boot) begin
      n_boot = 1'b0; n_pc_f = RESET_PC + 32'd4; n_pc_d = RESET_PC;
      n_f1   = 1'b0; n_s1 = 1'b0;
    end else begin
      n_boot = 1'b0;
      n_pc_f = pc_src ? pc_target : (stall ? m_pc_f : m_pc_f + 32'd4);
      n_pc_d = (stall && !pc_src) ? m_pc_d : m_pc_f;
      if (stall && !m_s1) n_tmp = imem_rdata;
      n_f1 = flush;
      n_s1 = stall;
    end
    @(posedge clk);
    #1;
    m_boot = n_boot; m_pc_f = n_pc_f; m_pc_d = n_pc_d;
    m_tmp  = n_tmp;  m_f1 = n_f1;     m_s1 = n_s1;
    check("pc_f",        pc_f,              m_pc_f);
    check("imem_addr",   imem_addr,         m_pc_f);
    check("pc_d",        pc_d,              m_pc_d);
    check("pc_plus4_d",  pc_plus4_d,        m_pc_d + 32'd4);
    check("inst_tmp_1d", inst_tmp_1d,       m_tmp);
    check("flush_1d",    32'(flush_1d),     32'(m_f1));
    check("stall_1d",    32'(stall_1d),     32'(m_s1));
  endtask

  task automatic set_in(input logic r, input logic s, input logic f,
                        input logic p, input logic [31:0] t);
    rst_n = r; stall = s; flush = f; pc_src = p; pc_target = t;
  endtask

  initial begin
    logic [31:0] r;
    ovr_en = 1'b0; ovr_val = '0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
    m_boot = 1'b1; m_pc_f = '0; m_pc_d = '0; m_tmp = '0; m_f1 = 1'b0; m_s1 = 1'b0;

    // {rst_n, stall, flush, pc_src, tgt, exp pc_f, exp pc_d, exp tmp, exp f1, exp s1}
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   KILL_PC,  32'h0,            1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h4,   32'h0,    32'h0,            1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,    32'h0,            1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'hC,   32'h8,    32'h0,            1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h10,  32'hC,    32'h0,            1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h10,  32'hC,    32'hA500_000C,    1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h10,  32'hC,    32'hA500_000C,    1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h10,  32'hC,    32'hA500_000C,    1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h14,  32'h10,   32'hA500_000C,    1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h14,  32'h10,   32'hA500_0010,    1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h200, 32'h14,   32'hA500_0010,    1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h204, 32'h200,  32'hA500_0010,    1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h208, 32'h204,  32'hA500_0010,    1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h20C, 32'h208,  32'hA500_0010,    1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h20C, 32'h208,  32'hA500_0208,    1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h210, 32'h20C,  32'hA500_0208,    1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].pc_src, vecs[i].tgt);
      tick();
      check($sformatf("vec%0d_pc_f", i),  pc_f,              vecs[i].e_pc_f);
      check($sformatf("vec%0d_pc_d", i),  pc_d,              vecs[i].e_pc_d);
      check($sformatf("vec%0d_tmp", i),   inst_tmp_1d,       vecs[i].e_tmp);
      check($sformatf("vec%0d_f1", i),    32'(flush_1d),     32'(vecs[i].e_f1));
      check($sformatf("vec%0d_s1", i),    32'(stall_1d),     32'(vecs[i].e_s1));
    end

    // PC wrap at the top of the address space; target low bits pass through
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    tick();
    check("wrap_tgt", pc_f, 32'hFFFF_FFF8);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("wrap_pre", pc_f, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_f", pc_f, 32'h0);
    check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4_d, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h302);
    tick();
    check("tgt_lowbits", pc_f, 32'h302);

    // reset while a stall is holding 0xDEADBEEF
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("hold_beef", inst_tmp_1d, 32'hDEAD_BEEF);
    ovr_en = 1'b0;
    tick();
    check("hold_beef2", inst_tmp_1d, 32'hDEAD_BEEF);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h500);
    tick();
    check("rst_pc_f", pc_f, RESET_PC);
    check("rst_pc_d", pc_d, KILL_PC);
    check("rst_tmp", inst_tmp_1d, 32'h0);
    check("rst_s1", 32'(stall_1d), 32'h0);
    check("rst_f1", 32'(flush_1d), 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("reboot_pc_d", pc_d, 32'h0);
    check("reboot_pc_f", pc_f, 32'h4);
    tick();
    check("reboot2_pc_d", pc_d, 32'h4);
    check("reboot2_pc_f", pc_f, 32'h8);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      rst_n  = ($urandom_range(0, 49) != 0);
      stall  = ($urandom_range(0, 9) < 3);
      flush  = ($urandom_range(0, 9) < 2);
      pc_src = ($urandom_range(0, 9) == 0);
      pc_target = {r[31:2], 2'b00};
      if ($urandom_range(0, 7) == 0) pc_target = 32'hFFFF_FFF0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
